hazard_unit_n: RTL and testbench

- Parametrised successor to the dual-lane hazard unit for the superscalar MIPS pipeline (F/D/E/M/W).
- Supports LANES issue lanes.
- Handles E-stage forwarding, load-use, branch and multiply stalls, and intra-bundle dependencies. A bundle with an intra-bundle dependency is split-issued over several cycles using an issue pointer.
- D-cache and I-cache miss stalls are tracked by clocked FSMs with ready handshakes and abort draining, not edge-triggered flags.

---
 rtl/hazard_unit_n.sv | 229 ++++++++++++++++++++++
 tb/tb_hazard_unit_n.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_n.sv
// Parametrised hazard unit for an N-lane F/D/E/M/W MIPS pipeline: forwarding, stalls, split issue, cache-miss FSMs.
// Optional lane-0 branch-compare forwarding from M when HAZARD_BRANCH_FWD_EN is defined.
module hazard_unit_n #(
  parameter  int unsigned LANES    = 2,
  parameter  int unsigned REGW     = 5,
  parameter  int unsigned MULT_LAT = 4,
  localparam int unsigned FW       = $clog2(2*LANES+1),
  localparam int unsigned PW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*REGW-1:0] rs_d,
  input  logic [LANES*REGW-1:0] rt_d,
  input  logic [LANES*REGW-1:0] wreg_d,
  input  logic [LANES-1:0]      regwrite_d,
  input  logic [LANES-1:0]      mfhilo_d,
  input  logic                  branch_d,
  input  logic [LANES*REGW-1:0] rs_e,
  input  logic [LANES*REGW-1:0] rt_e,
  input  logic [LANES*REGW-1:0] wreg_e,
  input  logic [LANES-1:0]      regwrite_e,
  input  logic [LANES-1:0]      memtoreg_e,
  input  logic [LANES*REGW-1:0] wreg_m,
  input  logic [LANES*REGW-1:0] wreg_w,
  input  logic [LANES-1:0]      regwrite_m,
  input  logic [LANES-1:0]      memtoreg_m,
  input  logic [LANES-1:0]      regwrite_w,
  input  logic                  mult_start_e,
  input  logic                  dmem_miss,
  input  logic                  dmem_ready,
  input  logic                  imem_miss,
  input  logic                  imem_ready,
  input  logic                  abort,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic [LANES-1:0]      flush_e_mask,
  output logic                  flush_w,
  output logic [LANES*FW-1:0]   fwd_a_e,
  output logic [LANES*FW-1:0]   fwd_b_e,
  output logic [FW-1:0]         fwd_a_d,
  output logic [FW-1:0]         fwd_b_d,
  output logic                  ifetch_discard,
  output logic [PW-1:0]         issue_ptr
);

  localparam int unsigned MCW = $clog2(MULT_LAT+1);

  typedef enum logic       {D_IDLE, D_WAIT} dstate_t;
  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_DRAIN} istate_t;

  dstate_t        r_dstate, w_dstate_nxt;
  istate_t        r_istate, w_istate_nxt;
  logic [MCW-1:0] r_mult_cnt;
  logic [PW-1:0]  r_issue_ptr, w_issue_ptr_nxt, w_dep_j;
  logic           w_dstall, w_istall, w_lwstall, w_branchstall, w_multstall;
  logic           w_dep_found, w_hit;

  function automatic logic [REGW-1:0] fld(input logic [LANES*REGW-1:0] v, input int k);
    return v[k*REGW +: REGW];
  endfunction

  function automatic logic src_hit(input logic [REGW-1:0] src, input logic [REGW-1:0] dst,
                                   input logic en);
    return (src != '0) && (src == dst) && en;
  endfunction

  // Later matches override earlier ones: W before M, lanes ascending, so M and younger lanes win.
  function automatic logic [FW-1:0] fwd_sel(input logic [REGW-1:0] src,
                                            input logic [LANES*REGW-1:0] wm, input logic [LANES-1:0] rwm,
                                            input logic [LANES*REGW-1:0] ww, input logic [LANES-1:0] rww);
    logic [FW-1:0] sel;
    sel = '0;
    for (int k = 0; k < LANES; k++)
      if (src_hit(src, fld(ww, k), rww[k])) sel = FW'(1 + LANES + k);
    for (int k = 0; k < LANES; k++)
      if (src_hit(src, fld(wm, k), rwm[k])) sel = FW'(1 + k);
    return sel;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dstate    <= D_IDLE;
      r_istate    <= I_IDLE;
      r_issue_ptr <= '0;
      r_mult_cnt  <= '0;
    end else begin
      r_dstate    <= w_dstate_nxt;
      r_istate    <= w_istate_nxt;
      r_issue_ptr <= w_issue_ptr_nxt;
      if (mult_start_e)            r_mult_cnt <= MCW'(MULT_LAT);
      else if (r_mult_cnt != '0)   r_mult_cnt <= r_mult_cnt - MCW'(1);
    end
  end

  always_comb begin
    stall_f         = 1'b0;
    stall_d         = 1'b0;
    stall_e         = 1'b0;
    stall_m         = 1'b0;
    flush_w         = 1'b0;
    flush_e_mask    = '0;
    fwd_a_e         = '0;
    fwd_b_e         = '0;
    fwd_a_d         = '0;
    fwd_b_d         = '0;
    ifetch_discard  = 1'b0;
    w_dstate_nxt    = r_dstate;
    w_istate_nxt    = r_istate;
    w_issue_ptr_nxt = r_issue_ptr;
    w_lwstall       = 1'b0;
    w_branchstall   = 1'b0;
    w_dep_found     = 1'b0;
    w_dep_j         = '0;
    w_hit           = 1'b0;

    for (int l = 0; l < LANES; l++) begin
      fwd_a_e[l*FW +: FW] = fwd_sel(fld(rs_e, l), wreg_m, regwrite_m, wreg_w, regwrite_w);
      fwd_b_e[l*FW +: FW] = fwd_sel(fld(rt_e, l), wreg_m, regwrite_m, wreg_w, regwrite_w);
    end

    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < LANES; k++)
        if (src_hit(fld(rs_d, l), fld(wreg_e, k), memtoreg_e[k]) ||
            src_hit(fld(rt_d, l), fld(wreg_e, k), memtoreg_e[k]))
          w_lwstall = 1'b1;

    // Lane-0 branch compares in D, so an E result or an M load cannot be used yet.
    for (int k = 0; k < LANES; k++) begin
      if (src_hit(fld(rs_d, 0), fld(wreg_e, k), regwrite_e[k]) ||
          src_hit(fld(rt_d, 0), fld(wreg_e, k), regwrite_e[k]) ||
          src_hit(fld(rs_d, 0), fld(wreg_m, k), memtoreg_m[k]) ||
          src_hit(fld(rt_d, 0), fld(wreg_m, k), memtoreg_m[k]))
        w_branchstall = branch_d;
`ifdef HAZARD_BRANCH_FWD_EN
      if (src_hit(fld(rs_d, 0), fld(wreg_m, k), regwrite_m[k])) fwd_a_d = FW'(1 + k);
      if (src_hit(fld(rt_d, 0), fld(wreg_m, k), regwrite_m[k])) fwd_b_d = FW'(1 + k);
`else
      if (src_hit(fld(rs_d, 0), fld(wreg_m, k), regwrite_m[k]) ||
          src_hit(fld(rt_d, 0), fld(wreg_m, k), regwrite_m[k]))
        w_branchstall = branch_d;
`endif
    end

    w_multstall = (|mfhilo_d) && (r_mult_cnt != '0);

    case (r_dstate)
      D_IDLE:  if (dmem_miss && !dmem_ready) w_dstate_nxt = D_WAIT;
      default: if (dmem_ready) w_dstate_nxt = D_IDLE;
    endcase
    w_dstall = (r_dstate == D_WAIT) || (dmem_miss && !dmem_ready);

    // An abort during a refill must still swallow the returning line.
    case (r_istate)
      I_IDLE: if (imem_miss) w_istate_nxt = I_WAIT;
      I_WAIT: begin
        if (imem_ready) begin
          w_istate_nxt   = I_IDLE;
          ifetch_discard = abort;
        end else if (abort) begin
          w_istate_nxt = I_DRAIN;
        end
      end
      default: if (imem_ready) begin
        w_istate_nxt   = I_IDLE;
        ifetch_discard = 1'b1;
      end
    endcase
    w_istall = (r_istate != I_IDLE) || imem_miss;

    // First lane past the pointer that reads a result written inside the issuing window.
    for (int j = 1; j < LANES; j++) begin
      if (!w_dep_found && (j > int'(r_issue_ptr))) begin
        w_hit = 1'b0;
        for (int i = 0; i < LANES; i++)
          if ((i >= int'(r_issue_ptr)) && (i < j) &&
              (src_hit(fld(rs_d, j), fld(wreg_d, i), regwrite_d[i]) ||
               src_hit(fld(rt_d, j), fld(wreg_d, i), regwrite_d[i])))
            w_hit = 1'b1;
        if (w_hit) begin
          w_dep_found = 1'b1;
          w_dep_j     = PW'(j);
        end
      end
    end

    if (w_dstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (w_lwstall || w_branchstall || w_multstall) begin
      stall_f      = 1'b1;
      stall_d      = 1'b1;
      flush_e_mask = '1;
    end else if (w_dep_found) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      for (int l = 0; l < LANES; l++)
        flush_e_mask[l] = (l < int'(r_issue_ptr)) || (l >= int'(w_dep_j));
      w_issue_ptr_nxt = w_dep_j;
    end else begin
      for (int l = 0; l < LANES; l++)
        flush_e_mask[l] = (l < int'(r_issue_ptr));
      w_issue_ptr_nxt = '0;
    end

    stall_f = stall_f || w_istall;

    if (rst) begin
      stall_f        = 1'b0;
      stall_d        = 1'b0;
      stall_e        = 1'b0;
      stall_m        = 1'b0;
      flush_w        = 1'b0;
      flush_e_mask   = '0;
      fwd_a_e        = '0;
      fwd_b_e        = '0;
      fwd_a_d        = '0;
      fwd_b_d        = '0;
      ifetch_discard = 1'b0;
    end
  end

  assign issue_ptr = r_issue_ptr;

endmodule

// File: tb/tb_hazard_unit_n.sv
// Directed self-checking bench for hazard_unit_n with LANES=2, REGW=5, MULT_LAT=4.
module tb_hazard_unit_n;
  localparam int unsigned LANES = 2;
  localparam int unsigned REGW  = 5;
  localparam int unsigned FW    = 3;

  logic clk = 1'b0;
  logic rst;
  logic [LANES*REGW-1:0] rs_d, rt_d, wreg_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic [LANES-1:0] regwrite_d, mfhilo_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
  logic branch_d, mult_start_e, dmem_miss, dmem_ready, imem_miss, imem_ready, abort;
  logic stall_f, stall_d, stall_e, stall_m, flush_w, ifetch_discard;
  logic [LANES-1:0] flush_e_mask;
  logic [LANES*FW-1:0] fwd_a_e, fwd_b_e;
  logic [FW-1:0] fwd_a_d, fwd_b_d;
  logic [0:0] issue_ptr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit_n #(.LANES(LANES), .REGW(REGW), .MULT_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .wreg_d(wreg_d), .regwrite_d(regwrite_d), .mfhilo_d(mfhilo_d),
    .branch_d(branch_d),
    .rs_e(rs_e), .rt_e(rt_e), .wreg_e(wreg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .wreg_m(wreg_m), .wreg_w(wreg_w), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .regwrite_w(regwrite_w), .mult_start_e(mult_start_e),
    .dmem_miss(dmem_miss), .dmem_ready(dmem_ready), .imem_miss(imem_miss), .imem_ready(imem_ready),
    .abort(abort),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_e_mask(flush_e_mask), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .ifetch_discard(ifetch_discard), .issue_ptr(issue_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs_d = '0; rt_d = '0; wreg_d = '0; regwrite_d = '0; mfhilo_d = '0; branch_d = 1'b0;
    rs_e = '0; rt_e = '0; wreg_e = '0; regwrite_e = '0; memtoreg_e = '0;
    wreg_m = '0; wreg_w = '0; regwrite_m = '0; memtoreg_m = '0; regwrite_w = '0;
    mult_start_e = 1'b0; dmem_miss = 1'b0; dmem_ready = 1'b0;
    imem_miss = 1'b0; imem_ready = 1'b0; abort = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live forwarding pattern: outputs must still read 0
    rst = 1'b1;
    clr();
    rs_e = {5'd3, 5'd0}; wreg_m = {5'd3, 5'd3}; regwrite_m = 2'b11;
    #12;
    chk("rst_fwd_a_e", fwd_a_e, 6'h00);
    chk("rst_stalls", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'h00);
    chk("rst_mask", flush_e_mask, 2'b00);
    chk("rst_ptr", issue_ptr, 1'b0);
    @(negedge clk); rst = 1'b0;

    // E-stage forwarding priorities
    @(negedge clk);
    rs_e = {5'd3, 5'd0}; wreg_m = {5'd3, 5'd3}; regwrite_m = 2'b11;
    wreg_w = {5'd0, 5'd3}; regwrite_w = 2'b01;
    #1 chk("fwd_m_lane1", fwd_a_e, 6'h10);
    chk("fwd_no_stall", stall_d, 1'b0);
    @(negedge clk); regwrite_m = 2'b00;
    #1 chk("fwd_w_lane0", fwd_a_e, 6'h18);
    @(negedge clk); wreg_w = {5'd3, 5'd3}; regwrite_w = 2'b11; rt_e = {5'd0, 5'd3};
    #1 chk("fwd_w_lane1", fwd_a_e, 6'h20);
    chk("fwd_b_w_lane1", fwd_b_e, 6'h04);
    @(negedge clk); rs_e = '0;
    #1 chk("fwd_zero_src", fwd_a_e, 6'h00);

    // Split issue: lane1 reads $5 written by lane0
    @(negedge clk); clr();
    wreg_d = {5'd0, 5'd5}; regwrite_d = 2'b01; rs_d = {5'd5, 5'd0};
    #1 chk("split1_stall", {stall_f, stall_d}, 2'b11);
    chk("split1_mask", flush_e_mask, 2'b10);
    chk("split1_ptr", issue_ptr, 1'b0);
    @(negedge clk);
    #1 chk("split2_ptr", issue_ptr, 1'b1);
    chk("split2_stall_d", stall_d, 1'b0);
    chk("split2_mask", flush_e_mask, 2'b01);
    @(negedge clk); clr();
    #1 chk("split3_ptr", issue_ptr, 1'b0);
    chk("split3_mask", flush_e_mask, 2'b00);
    @(negedge clk);
    wreg_d = {5'd5, 5'd0}; regwrite_d = 2'b10; rs_d = {5'd0, 5'd5};
    #1 chk("older_reader_no_split", {stall_d, flush_e_mask}, 3'b000);

    // Load-use
    @(negedge clk); clr();
    memtoreg_e = 2'b10; wreg_e = {5'd8, 5'd0}; rt_d = {5'd0, 5'd8};
    #1 chk("lw_stall_fd", {stall_f, stall_d, stall_e}, 3'b110);
    chk("lw_mask", flush_e_mask, 2'b11);
    @(negedge clk); clr();
    #1 chk("lw_ptr_held", issue_ptr, 1'b0);
    chk("lw_released", stall_d, 1'b0);

    // Branch against an M-stage ALU result
    @(negedge clk); clr();
    branch_d = 1'b1; rs_d = {5'd0, 5'd9}; wreg_m = {5'd9, 5'd0}; regwrite_m = 2'b10;
`ifdef HAZARD_BRANCH_FWD_EN
    #1 chk("br_m_stall", stall_d, 1'b0);
    chk("br_fwd_a_d", fwd_a_d, 3'd2);
`else
    #1 chk("br_m_stall", stall_d, 1'b1);
    chk("br_fwd_a_d", fwd_a_d, 3'd0);
`endif
    @(negedge clk); clr();
    branch_d = 1'b1; rt_d = {5'd0, 5'd9}; wreg_e = {5'd0, 5'd9}; regwrite_e = 2'b01;
    #1 chk("br_e_stall", {stall_d, flush_e_mask}, 3'b111);

    // D-cache miss held five cycles, lwstall overlapping in the third
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); clr();
      dmem_miss = 1'b1;
      if (c == 2) begin memtoreg_e = 2'b10; wreg_e = {5'd8, 5'd0}; rt_d = {5'd0, 5'd8}; end
      #1 chk("dmiss_stalls", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'h1f);
      chk("dmiss_mask", flush_e_mask, 2'b00);
    end
    @(negedge clk); clr(); dmem_ready = 1'b1;
    #1 chk("dready_stalls", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'h1f);
    @(negedge clk); clr();
    #1 chk("dmiss_done", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'h00);

    // I-cache miss, abort two cycles in, refill three cycles later
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); clr();
      imem_miss = 1'b1;
      abort = (c == 2);
      #1 chk("imiss_stall", {stall_f, stall_d, ifetch_discard}, 3'b100);
    end
    @(negedge clk); clr(); imem_ready = 1'b1;
    #1 chk("idrain_discard", {stall_f, ifetch_discard}, 2'b11);
    @(negedge clk); clr();
    #1 chk("imiss_done", {stall_f, ifetch_discard}, 2'b00);

    // Abort coincident with refill completion
    @(negedge clk); clr(); imem_miss = 1'b1;
    #1 chk("imiss2_stall", stall_f, 1'b1);
    @(negedge clk); clr(); imem_ready = 1'b1; abort = 1'b1;
    #1 chk("ready_abort_discard", {stall_f, ifetch_discard}, 2'b11);
    @(negedge clk); clr();
    #1 chk("ready_abort_idle", {stall_f, ifetch_discard}, 2'b00);

    // Multiply: counter 4,3,2,1 stalls mfhi, released at 0
    @(negedge clk); clr(); mult_start_e = 1'b1;
    #1 chk("mult_start_nostall", stall_d, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); clr(); mfhilo_d = 2'b01;
      #1 chk("mult_stall", {stall_d, flush_e_mask}, 3'b111);
    end
    @(negedge clk);
    #1 chk("mult_release", stall_d, 1'b0);

    // Reset in the middle of a multiply count
    @(negedge clk); clr(); mult_start_e = 1'b1;
    @(negedge clk); clr(); mfhilo_d = 2'b01;
    #1 chk("mult2_stall", stall_d, 1'b1);
    @(negedge clk); rst = 1'b1;
    #1 chk("midrst_outputs", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_e_mask}, 7'h00);
    chk("midrst_ptr", issue_ptr, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1 chk("midrst_cnt_cleared", stall_d, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
